// File: rtl/seq_instrucao.sv
// seq_instrucao: instruction sequencer for a simple multi-cycle processor.
// Walks each instruction through fetch, decode, optional user-input or data
// memory wait, and a single write-back cycle, plus a halt state that waits
// for a resume request.
// Optional feature: define SEQ_CONTADOR_INSTR_EN to build the 32-bit
// retired-instruction counter; otherwise instr_count is tied to zero.
module seq_instrucao (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  opcode,
  input  logic        escreveR,
  input  logic        escreveM,
  input  logic        escreverOut,
  input  logic        halt,
  input  logic        jump,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        in_valid,
  input  logic        continuar,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        ir_en,
  output logic        pc_en,
  output logic        pc_jump,
  output logic        reg_we,
  output logic        mem_we,
  output logic        out_we,
  output logic        in_ack,
  output logic        halted,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    BUSCA      = 3'd0,
    DECODIFICA = 3'd1,
    ESPERA_IN  = 3'd2,
    MEMORIA    = 3'd3,
    ESCRITA    = 3'd4,
    PARADO     = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic   is_mem_op;

  // Opcodes that need a data-memory access before write-back
  always_comb begin
    is_mem_op = (opcode == 5'b01111) || (opcode == 5'b10001) ||
                (opcode == 5'b11010) || (opcode == 5'b11011);
  end

  // State register; reset drops straight back to fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUSCA;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode; outputs are forced low while in reset so
  // nothing (not even the fetch request) leaks out before the first edge
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    ir_en    = 1'b0;
    pc_en    = 1'b0;
    pc_jump  = 1'b0;
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    out_we   = 1'b0;
    in_ack   = 1'b0;
    halted   = 1'b0;

    case (state_q)
      BUSCA: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_en   = 1'b1;
          state_d = DECODIFICA;
        end
      end

      DECODIFICA: begin
        if (halt) begin
          state_d = PARADO;
        end else if (opcode == 5'b00010) begin
          state_d = ESPERA_IN;
        end else if (is_mem_op) begin
          state_d = MEMORIA;
        end else begin
          state_d = ESCRITA;
        end
      end

      ESPERA_IN: begin
        if (in_valid) begin
          in_ack  = 1'b1;
          state_d = ESCRITA;
        end
      end

      MEMORIA: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          mem_we  = escreveM;
          state_d = ESCRITA;
        end
      end

      ESCRITA: begin
        reg_we  = escreveR;
        out_we  = escreverOut;
        pc_en   = 1'b1;
        pc_jump = jump;
        state_d = BUSCA;
      end

      PARADO: begin
        halted = 1'b1;
        if (continuar) begin
          pc_en   = 1'b1;
          state_d = BUSCA;
        end
      end

      default: begin
        state_d = BUSCA;
      end
    endcase

    if (!rst_n) begin
      state_d  = BUSCA;
      imem_req = 1'b0;
      dmem_req = 1'b0;
      ir_en    = 1'b0;
      pc_en    = 1'b0;
      pc_jump  = 1'b0;
      reg_we   = 1'b0;
      mem_we   = 1'b0;
      out_we   = 1'b0;
      in_ack   = 1'b0;
      halted   = 1'b0;
    end
  end

`ifdef SEQ_CONTADOR_INSTR_EN
  logic [31:0] count_q, count_d;

  // One retirement per write-back cycle; leaving halt does not count
  always_comb begin
    count_d = count_q;
    if (state_q == ESCRITA) begin
      count_d = count_q + 32'd1;
    end
  end

  // Retired-instruction counter register, wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign instr_count = count_q;
`else
  assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_seq_instrucao.sv
// tb_seq_instrucao: self-checking bench for seq_instrucao.
// An instruction-level model expands each instruction into its per-cycle
// {inputs, expected outputs} records; the records are then applied and
// compared cycle by cycle. Directed instructions, random instructions and
// hand-written reset-abandon sequences are covered.
module tb_seq_instrucao;

  logic        clk;
  logic        rst_n;
  logic [4:0]  opcode;
  logic        escreveR, escreveM, escreverOut, halt, jump;
  logic        imem_ready, dmem_ready, in_valid, continuar;
  logic        imem_req, dmem_req, ir_en, pc_en, pc_jump;
  logic        reg_we, mem_we, out_we, in_ack, halted;
  logic [31:0] instr_count;

  int checks;
  int failures;

  // ctrl = {escreveR, escreveM, escreverOut, halt, jump}
  // rdy  = {imem_ready, dmem_ready, in_valid, continuar}
  // exp  = {imem_req, dmem_req, ir_en, pc_en, pc_jump,
  //         reg_we, mem_we, out_we, in_ack, halted}
  typedef struct {
    logic [4:0]  op;
    logic [4:0]  ctrl;
    logic [3:0]  rdy;
    logic [9:0]  exp;
    logic [31:0] cnt;
    string       tag;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] model_cnt;

  seq_instrucao dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .escreveR    (escreveR),
    .escreveM    (escreveM),
    .escreverOut (escreverOut),
    .halt        (halt),
    .jump        (jump),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .in_valid    (in_valid),
    .continuar   (continuar),
    .imem_req    (imem_req),
    .dmem_req    (dmem_req),
    .ir_en       (ir_en),
    .pc_en       (pc_en),
    .pc_jump     (pc_jump),
    .reg_we      (reg_we),
    .mem_we      (mem_we),
    .out_we      (out_we),
    .in_ack      (in_ack),
    .halted      (halted),
    .instr_count (instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [9:0] ex(input logic i_req, input logic d_req,
                                    input logic ir, input logic pc,
                                    input logic pj, input logic rw,
                                    input logic mw, input logic ow,
                                    input logic ia, input logic hl);
    return {i_req, d_req, ir, pc, pj, rw, mw, ow, ia, hl};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [31:0] exp_count(input logic [31:0] c);
`ifdef SEQ_CONTADOR_INSTR_EN
    return c;
`else
    return 32'd0 & c;
`endif
  endfunction

  task automatic push_cycle(input logic [4:0] op, input logic [4:0] ctrl,
                            input logic [3:0] rdy, input logic [9:0] e,
                            input string tag);
    vec_t v;
    v.op   = op;
    v.ctrl = ctrl;
    v.rdy  = rdy;
    v.exp  = e;
    v.cnt  = model_cnt;
    v.tag  = tag;
    vq.push_back(v);
  endtask

  // Instruction-level model: fetch, decode, optional wait phase, then
  // write-back (or halt until resume). Waits are counted in cycles.
  task automatic add_instr(input logic [4:0] op, input logic er,
                           input logic em, input logic eo, input logic h,
                           input logic j, input int fw, input int iw,
                           input int dw, input int hw, input string tag);
    logic [4:0] ctrl;
    bit         is_mem;
    ctrl   = {er, em, eo, h, j};
    is_mem = (op == 5'b01111) || (op == 5'b10001) ||
             (op == 5'b11010) || (op == 5'b11011);

    for (int k = 0; k < fw; k++)
      push_cycle(op, ctrl, {1'b0, rb(), rb(), rb()},
                 ex(1,0,0,0,0,0,0,0,0,0), {tag, ".fetchwait"});
    push_cycle(op, ctrl, {1'b1, rb(), rb(), rb()},
               ex(1,0,1,0,0,0,0,0,0,0), {tag, ".fetch"});
    // continuar held high during a halting decode must not resume yet
    push_cycle(op, ctrl, {1'b0, rb(), rb(), h ? 1'b1 : rb()},
               ex(0,0,0,0,0,0,0,0,0,0), {tag, ".decode"});

    if (h) begin
      for (int k = 0; k < hw; k++)
        push_cycle(op, ctrl, {1'b0, rb(), rb(), 1'b0},
                   ex(0,0,0,0,0,0,0,0,0,1), {tag, ".halted"});
      push_cycle(op, ctrl, {1'b0, rb(), rb(), 1'b1},
                 ex(0,0,0,1,0,0,0,0,0,1), {tag, ".resume"});
      return;
    end

    if (op == 5'b00010) begin
      for (int k = 0; k < iw; k++)
        push_cycle(op, ctrl, {1'b0, rb(), 1'b0, rb()},
                   ex(0,0,0,0,0,0,0,0,0,0), {tag, ".inwait"});
      push_cycle(op, ctrl, {1'b0, rb(), 1'b1, rb()},
                 ex(0,0,0,0,0,0,0,0,1,0), {tag, ".inack"});
    end else if (is_mem) begin
      for (int k = 0; k < dw; k++)
        push_cycle(op, ctrl, {1'b0, 1'b0, rb(), rb()},
                   ex(0,1,0,0,0,0,0,0,0,0), {tag, ".memwait"});
      push_cycle(op, ctrl, {1'b0, 1'b1, rb(), rb()},
                 ex(0,1,0,0,0,0,em,0,0,0), {tag, ".memdone"});
    end

    push_cycle(op, ctrl, {1'b0, rb(), rb(), rb()},
               ex(0,0,0,1,j,er,0,eo,0,0), {tag, ".write"});
    model_cnt = model_cnt + 32'd1;
  endtask

  task automatic applyStimulus(input vec_t v);
    opcode      = v.op;
    {escreveR, escreveM, escreverOut, halt, jump} = v.ctrl;
    {imem_ready, dmem_ready, in_valid, continuar} = v.rdy;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    logic [9:0] got;
    got = {imem_req, dmem_req, ir_en, pc_en, pc_jump,
           reg_we, mem_we, out_we, in_ack, halted};
    checks++;
    if (got !== v.exp) begin
      failures++;
      $display("[TB] FAIL %s (#%0d) outputs got=%b want=%b", v.tag, idx,
               got, v.exp);
    end
    checks++;
    if (instr_count !== exp_count(v.cnt)) begin
      failures++;
      $display("[TB] FAIL %s (#%0d) instr_count got=%h want=%h", v.tag, idx,
               instr_count, exp_count(v.cnt));
    end
  endtask

  task automatic check_zero(input string tag);
    logic [9:0] got;
    got = {imem_req, dmem_req, ir_en, pc_en, pc_jump,
           reg_we, mem_we, out_we, in_ack, halted};
    checks++;
    if (got !== 10'd0) begin
      failures++;
      $display("[TB] FAIL %s outputs got=%b want=%b", tag, got, 10'd0);
    end
    checks++;
    if (instr_count !== 32'd0) begin
      failures++;
      $display("[TB] FAIL %s instr_count got=%h want=%h", tag, instr_count,
               32'd0);
    end
  endtask

  // Applies up to n queued cycles (all if n < 0), sampling on the falling
  // edge; enters and leaves just after a rising edge. Clears the queue.
  task automatic run_queue(input int n);
    int lim;
    lim = (n < 0 || n > vq.size()) ? vq.size() : n;
    for (int i = 0; i < lim; i++) begin
      applyStimulus(vq[i]);
      @(negedge clk);
      checkOutput(vq[i], i);
      @(posedge clk);
      #1;
    end
    vq.delete();
  endtask

  // Asserts reset asynchronously with the pending completion input high
  task automatic reset_abandon(input string tag);
    rst_n = 1'b0;
    #1;
    check_zero({tag, ".async"});
    @(posedge clk);
    #1;
    check_zero({tag, ".held"});
    rst_n     = 1'b1;
    model_cnt = 32'd0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    model_cnt   = 32'd0;
    rst_n       = 1'b0;
    opcode      = 5'd0;
    escreveR    = 1'b1;
    escreveM    = 1'b1;
    escreverOut = 1'b1;
    halt        = 1'b0;
    jump        = 1'b1;
    imem_ready  = 1'b1;
    dmem_ready  = 1'b1;
    in_valid    = 1'b1;
    continuar   = 1'b1;

    // Reset state with every input asserted
    #2;
    check_zero("reset.initial");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero("reset.clocked");
    rst_n = 1'b1;

    // Directed instructions
    add_instr(5'b01011, 1, 0, 0, 0, 0, 0, 0, 0, 0,   "add");
    add_instr(5'b01111, 0, 1, 0, 0, 0, 1, 0, 2, 0,   "store");
    add_instr(5'b10001, 1, 0, 0, 0, 0, 0, 0, 0, 0,   "load");
    add_instr(5'b00010, 1, 0, 0, 0, 0, 0, 5, 0, 0,   "in");
    add_instr(5'b00000, 0, 0, 0, 1, 0, 0, 0, 0, 100, "hlt");
    add_instr(5'b01100, 0, 0, 0, 0, 1, 0, 0, 0, 0,   "jz_taken");
    add_instr(5'b01100, 0, 0, 0, 0, 0, 0, 0, 0, 0,   "jz_not");
    add_instr(5'b11111, 0, 0, 1, 0, 0, 2, 0, 0, 0,   "out");
    add_instr(5'b11010, 0, 1, 0, 0, 0, 0, 0, 0, 0,   "mem_d0");
    run_queue(-1);

    // Random instruction stream
    for (int n = 0; n < 60; n++) begin
      logic [4:0] op;
      int         sel;
      logic       h;
      sel = $urandom_range(0, 9);
      h   = (sel == 0);
      case (sel)
        1, 2:    op = 5'b00010;
        3:       op = 5'b01111;
        4:       op = 5'b10001;
        5:       op = ($urandom_range(0, 1) == 1) ? 5'b11010 : 5'b11011;
        default: op = 5'($urandom_range(0, 31));
      endcase
      add_instr(op, rb(), rb(), rb(), h, rb(),
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 4), "rand");
    end
    run_queue(-1);

    // Reset in the middle of a data-memory wait
    add_instr(5'b01111, 0, 1, 0, 0, 0, 0, 0, 4, 0, "rst_mem");
    run_queue(3);
    escreveM   = 1'b1;
    dmem_ready = 1'b1;
    reset_abandon("rst_mem");

    // Reset in the middle of a user-input wait
    add_instr(5'b00010, 1, 0, 0, 0, 0, 0, 4, 0, 0, "rst_in");
    run_queue(3);
    in_valid = 1'b1;
    reset_abandon("rst_in");

    // Execution resumes cleanly and the count restarts from zero
    add_instr(5'b01011, 1, 0, 0, 0, 0, 0, 0, 0, 0, "post_rst_add");
    add_instr(5'b01011, 1, 0, 1, 0, 1, 0, 0, 0, 0, "post_rst_add2");
    run_queue(-1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
